// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: fetch-state encoding,
// PC step and instruction field widths.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int PC_STEP = 4;
    localparam int IMM_W   = 16;
    localparam int JTGT_W  = 26;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC computation: target generation, jr > jump > branch >
// sequential priority, and the illegal-address check on the chosen target.
module next_pc_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int MEM_BYTES = 32768
) (
    input  logic [PC_W-1:0]   pc,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump,
    input  logic [JTGT_W-1:0] jump_target,
    input  logic              jump_reg,
    input  logic [PC_W-1:0]   reg_target,
    output logic [PC_W-1:0]   pc_plus4,
    output logic [PC_W-1:0]   next_pc,
    output logic              illegal
);

    localparam logic [PC_W:0] MEM_LIMIT = (PC_W+1)'(MEM_BYTES);

    logic [PC_W-1:0] branch_off;
    logic [PC_W-1:0] jump_pc;

    always_comb begin
        pc_plus4   = pc + PC_W'(PC_STEP);
        branch_off = {{(PC_W-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};
        // Jump keeps the top region bits of pc+4 and replaces the low 28.
        jump_pc        = pc_plus4;
        jump_pc[27:0]  = {jump_target, 2'b00};

        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = reg_target;
        end else if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end

        illegal = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= MEM_LIMIT);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter stage: boot window driving the imem image load, then
// sequential/redirected fetch with stall, halt and sticky fault on a bad PC.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int MEM_BYTES   = 32768,
    parameter int RESET_PC    = 0,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump,
    input  logic [JTGT_W-1:0] jump_target,
    input  logic              jump_reg,
    input  logic [PC_W-1:0]   reg_target,
    input  logic              halt_req,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic              imem_init,
    output logic              fetch_valid,
    output logic [CNT_W-1:0]  instr_count,
    output logic              halted,
    output logic              fault,
    output fetch_state_e      state_dbg
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_RST    = PC_W'(RESET_PC);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic [PC_W-1:0]  next_pc;
    logic             illegal;

    next_pc_sel #(
        .PC_W      (PC_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_next_pc_sel (
        .pc           (pc_q),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .illegal      (illegal)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        boot_cnt_d = boot_cnt_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end
            ST_RUN: begin
                // halt_req wins over everything, so a bad redirect beside it never faults.
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    if (illegal) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d  = next_pc;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= PC_RST;
            boot_cnt_q <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_cnt_q <= boot_cnt_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign fault       = fault_q;
    assign imem_init   = (state_q == ST_BOOT);
    assign fetch_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table for the main fetch flow,
// plus hand-written reset, fault and halt sequences.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              branch_taken;
    logic [15:0]       branch_imm;
    logic              jump;
    logic [25:0]       jump_target;
    logic              jump_reg;
    logic [31:0]       reg_target;
    logic              halt_req;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              imem_init;
    logic              fetch_valid;
    logic [31:0]       instr_count;
    logic              halted;
    logic              fault;
    fetch_state_e      state_dbg;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .PC_W        (32),
        .MEM_BYTES   (32768),
        .RESET_PC    (0),
        .BOOT_CYCLES (2),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .halt_req     (halt_req),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_init    (imem_init),
        .fetch_valid  (fetch_valid),
        .instr_count  (instr_count),
        .halted       (halted),
        .fault        (fault),
        .state_dbg    (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] jt;
        logic        jr;
        logic [31:0] rt;
        logic        hreq;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        chk_cnt;
        logic        e_fault;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic b, logic [15:0] im, logic j, logic [25:0] jt,
                                logic jr, logic [31:0] rt, logic h, logic [31:0] epc,
                                logic [31:0] ecnt, logic cc, logic ef, logic eh);
        vec_t v;
        v.stall = s; v.br = b; v.imm = im; v.jmp = j; v.jt = jt; v.jr = jr; v.rt = rt;
        v.hreq = h; v.e_pc = epc; v.e_cnt = ecnt; v.chk_cnt = cc; v.e_fault = ef;
        v.e_halted = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; branch_imm = '0; jump = 0; jump_target = '0;
        jump_reg = 0; reg_target = '0; halt_req = 0;
    endtask

    task automatic apply(input vec_t v);
        stall = v.stall; branch_taken = v.br; branch_imm = v.imm; jump = v.jmp;
        jump_target = v.jt; jump_reg = v.jr; reg_target = v.rt; halt_req = v.hreq;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_imem_init"}, {31'b0, imem_init}, 32'd1);
        chk({tag, "_fetch_valid"}, {31'b0, fetch_valid}, 32'd0);
        chk({tag, "_instr_count"}, instr_count, 32'd0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
        chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
        chk({tag, "_state"}, {30'b0, state_dbg}, {30'b0, ST_BOOT});
    endtask

    // Hold reset 3 cycles, release, and walk the two boot edges.
    task automatic do_reset(input string tag);
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals({tag, "_rst"});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_boot1_imem"}, {31'b0, imem_init}, 32'd1);
        chk({tag, "_boot1_fv"}, {31'b0, fetch_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_boot2_imem"}, {31'b0, imem_init}, 32'd0);
        chk({tag, "_boot2_fv"}, {31'b0, fetch_valid}, 32'd1);
        chk({tag, "_boot2_pc"}, pc, 32'h0);
        chk({tag, "_boot2_cnt"}, instr_count, 32'd0);
        chk({tag, "_boot2_state"}, {30'b0, state_dbg}, {30'b0, ST_RUN});
    endtask

    task automatic step_one(input vec_t v);
        @(negedge clk);
        apply(v);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();

        //        stall br imm       jmp jt          jr rt          h  e_pc       e_cnt cc ef eh
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  0, 32'h04, 1,  1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  0, 32'h08, 2,  1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 26'h10, 0, 32'h0,  0, 32'h08, 2,  1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 26'h10, 0, 32'h0,  0, 32'h08, 2,  1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 26'h10, 0, 32'h0,  0, 32'h08, 2,  1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  0, 32'h0C, 3,  1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  0, 32'h10, 4,  1, 0, 0));
        vecs.push_back(mk(0, 1, 16'hFFFE, 0, 26'h0,  0, 32'h0,  0, 32'h0C, 5,  1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  0, 32'h10, 6,  1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0004, 0, 26'h0,  0, 32'h0,  0, 32'h24, 7,  1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  1, 32'h20, 0, 32'h20, 8,  1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0100, 1, 26'h80, 1, 32'h40, 0, 32'h40, 9,  1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 26'hC0, 0, 32'h0,  0, 32'h300, 10, 1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0040, 1, 26'h10, 0, 32'h0,  0, 32'h40, 11, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  0, 32'h44, 12, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  1, 32'h42, 0, 32'h44, 0,  0, 1, 1));
        vecs.push_back(mk(0, 1, 16'h0004, 1, 26'h20, 1, 32'h80, 0, 32'h44, 0,  0, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,  1, 32'h44, 0,  0, 1, 1));

        do_reset("r1");

        for (int i = 0; i < vecs.size(); i++) begin
            step_one(vecs[i]);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
            if (vecs[i].chk_cnt)
                chk($sformatf("v%0d_cnt", i), instr_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].e_fault});
            chk($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
            chk($sformatf("v%0d_fv", i), {31'b0, fetch_valid}, {31'b0, ~vecs[i].e_halted});
        end

        // Out-of-range jr target at the memory size boundary.
        do_reset("r2");
        step_one(mk(0, 0, 16'h0, 0, 26'h0, 1, 32'h8000, 0, 0, 0, 0, 0, 0));
        chk("oor_fault", {31'b0, fault}, 32'd1);
        chk("oor_halted", {31'b0, halted}, 32'd1);
        chk("oor_pc", pc, 32'h0);
        step_one(mk(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("oor_pc_frozen", pc, 32'h0);
        chk("oor_state", {30'b0, state_dbg}, {30'b0, ST_HALT});

        // Last legal address is reachable, then sequential step off the end faults.
        do_reset("r3");
        step_one(mk(0, 0, 16'h0, 0, 26'h0, 1, 32'h7FFC, 0, 0, 0, 0, 0, 0));
        chk("top_pc", pc, 32'h7FFC);
        chk("top_fault", {31'b0, fault}, 32'd0);
        step_one(mk(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("wrap_fault", {31'b0, fault}, 32'd1);
        chk("wrap_pc", pc, 32'h7FFC);

        // halt_req alongside an illegal jr: halt without fault.
        do_reset("r4");
        step_one(mk(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        step_one(mk(1, 0, 16'h0, 0, 26'h0, 1, 32'h42, 1, 0, 0, 0, 0, 0));
        chk("hreq_halted", {31'b0, halted}, 32'd1);
        chk("hreq_fault", {31'b0, fault}, 32'd0);
        chk("hreq_pc", pc, 32'h4);
        chk("hreq_cnt", instr_count, 32'd1);
        chk("hreq_fv", {31'b0, fetch_valid}, 32'd0);

        // Asynchronous reset while halted, asserted mid-cycle.
        @(negedge clk);
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async_halt");

        // Asynchronous reset during a stall.
        do_reset("r5");
        step_one(mk(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        step_one(mk(1, 0, 16'h0, 1, 26'h40, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("stall_pc", pc, 32'h4);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async_stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and next-PC stage feeding the 32-bit byte address into the instruction memory.
- Holds a short boot window. During that window it drives the memory's image-load request. It then steps PC by 4 per cycle.
- Redirects PC on branch, j/jal and jr using decoded fields returned from the memory outputs. Supports stall and halt, and flags fetch faults.

Parameters:
- PC_W, 32, program counter width in bits.
- MEM_BYTES, 32768, instruction memory size in bytes; must be a power of two.
- RESET_PC, 0, PC value loaded on reset and held through boot.
- BOOT_CYCLES, 2, number of cycles imem_init stays asserted after reset release; must be at least 1.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; no redirect is taken while high.
- branch_taken  in  1  conditional branch resolved taken.
- branch_imm  in  16  branch offset in words (ins_15_0).
- jump  in  1  j/jal redirect.
- jump_target  in  26  word target (ins_25_0).
- jump_reg  in  1  jr redirect.
- reg_target  in  PC_W  jr byte target.
- halt_req  in  1  request to stop fetching.
- pc  out  PC_W  current fetch address.
- pc_plus4  out  PC_W  pc+4, used as the jal link value.
- imem_init  out  1  instruction-memory image-load request.
- fetch_valid  out  1  pc holds a fetchable address this cycle.
- instr_count  out  CNT_W  number of fetches advanced.
- halted  out  1  unit is in HALT.
- fault  out  1  sticky; set on an illegal PC.

Behaviour:
- States: BOOT, RUN, HALT.
- While rst=0, asynchronously force: state=BOOT, pc=RESET_PC, boot counter=0, imem_init=1, fetch_valid=0, instr_count=0, halted=0, fault=0.
- BOOT:
  - pc held at RESET_PC; all redirect inputs ignored.
  - Boot counter increments each cycle.
  - When it reaches BOOT_CYCLES-1: next state RUN, imem_init=0, fetch_valid=1.
  - imem_init is therefore high for exactly BOOT_CYCLES rising edges after reset release.
- RUN:
  - stall=1: pc and instr_count hold; redirects are dropped, so the decoder must re-present them.
  - Otherwise the next pc is selected by priority jr > jump > branch_taken > sequential:
    - jr: reg_target.
    - jump: {pc_plus4[PC_W-1:28], jump_target, 2'b00}.
    - branch: pc_plus4 + (sign_extend(branch_imm) << 2), modulo 2^PC_W.
    - sequential: pc+4.
  - instr_count increments by 1 on every non-stalled RUN cycle and wraps at 2^CNT_W.
  - pc_plus4 = pc + 4, combinational, modulo 2^PC_W.
- Faults:
  - A next pc with bits [1:0] != 0, or with a value >= MEM_BYTES, is illegal.
  - On an illegal next pc: pc is not updated, fault=1, next state HALT.
- halt_req=1 in RUN:
  - Takes priority over stall and all redirects.
  - pc holds; next state HALT.
- HALT:
  - halted=1, fetch_valid=0; pc and instr_count frozen.
  - All inputs ignored. Exit only through reset.
- Simultaneous halt_req with a fault-causing redirect: HALT is entered with fault=0, because the redirect is never evaluated.
- Reset mid-operation, including in HALT or during a stall: immediate return to the reset values above, asynchronously.
- Latency:
  - A redirect presented in cycle N appears on pc after the rising edge ending cycle N.
  - fetch_valid rises the same edge BOOT exits.

Decomposition:
- Shared package: the fetch-state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the PC step constant 4, and the instruction field widths (16-bit immediate, 26-bit jump field).
- One sub-module, next_pc_sel: purely combinational target computation, priority selection, and illegal-address check.
- pc_fetch_unit holds the FSM, PC register, boot counter and instruction counter.

Test Plan:
- Reset low 3 cycles then high, BOOT_CYCLES=2 -> imem_init=1 for 2 edges, then fetch_valid=1; pc sequence 0,4,8,12; instr_count 1,2,3.
- At pc=0x10: branch_taken=1, branch_imm=0xFFFE -> next pc=0x0C. At pc=0x10: branch_imm=0x0004 -> next pc=0x24.
- At pc=0x20, assert jump, jump_reg and branch_taken together with reg_target=0x40 -> pc=0x40 (jr wins). jump alone with jump_target=0x00000C0 -> pc=0x300.
- stall held 3 cycles at pc=0x08 with jump asserted -> pc stays 0x08 and instr_count is unchanged; after release pc=0x0C.
- jr with reg_target=0x42 -> fault=1, halted=1, pc unchanged. jr with reg_target=0x8000 at MEM_BYTES=32768 -> same result. Subsequent inputs have no effect.
- halt_req in the same cycle as an illegal jr -> halted=1, fault=0. Asserting rst low while in HALT -> all outputs return to reset values immediately.
